// File: rtl/fir_param_pipelined_pkg.sv
// Shared definitions for the parametrised pipelined FIR engine.
package fir_param_pipelined_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fir_state_t;

    // Cycles from read strobe to write strobe: RAM, delay line, product, sum/round.
    localparam int unsigned PIPE_LAT = 4;

    // Coefficient bank reset pattern: identity filter (tap 0 = 1, others 0).
    function automatic int reset_coef(input int unsigned k);
        return (k == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation.
module fir_round_sat #(
    parameter int ACC_W  = 19,
    parameter int DATA_W = 8
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic        [4:0]        shift,
    output logic signed [DATA_W-1:0] value,
    output logic                     sat
);

    // Headroom so the rounding constant (up to 2^30) can never overflow.
    localparam int     EXT_W = ACC_W + 33;
    localparam longint MAXV  = (longint'(1) << (DATA_W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) << (DATA_W - 1));

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] shifted;

    // Round, shift, then clip to the output range.
    always_comb begin
        ext = EXT_W'(acc);
        rnd = '0;
        if (shift != 5'd0) begin
            rnd[shift - 5'd1] = 1'b1;
        end
        shifted = (ext + rnd) >>> shift;
        sat     = 1'b0;
        value   = shifted[DATA_W-1:0];
        if (shifted > EXT_W'(MAXV)) begin
            value = MAXV[DATA_W-1:0];
            sat   = 1'b1;
        end else if (shifted < EXT_W'(MINV)) begin
            value = MINV[DATA_W-1:0];
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/fir_param_pipelined.sv
// Memory-to-memory pipelined FIR: reads samples on port A, writes filtered
// samples on port B four cycles later, one per cycle.
module fir_param_pipelined
    import fir_param_pipelined_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] input_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [ADDR_W-1:0] sample_count,
    input  logic [4:0]        out_shift,
    input  logic              coef_we,
    input  logic [3:0]        coef_idx,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic              mem_rd_en_a,
    input  logic [DATA_W-1:0] mem_data_out_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    output logic [DATA_W-1:0] mem_data_in_b,
    output logic              mem_we_b
);

    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    fir_state_t state_q, state_d;

    logic [ADDR_W-1:0] in_base_q, in_base_d, out_base_q, out_base_d;
    logic [ADDR_W-1:0] count_q, count_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [4:0]        shift_q, shift_d;
    logic              sat_q, sat_d;
    logic [PIPE_LAT:1] vld_q, vld_d;

    logic signed [DATA_W-1:0] x_q[TAPS], x_d[TAPS];
    logic signed [COEF_W-1:0] coef_q[TAPS], coef_d[TAPS];
    logic signed [PROD_W-1:0] prod_q[TAPS], prod_d[TAPS];
    logic signed [DATA_W-1:0] y_q, y_d;

    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] rs_val;
    logic                     rs_sat;
    logic                     start_acc;
    logic                     rd_en;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign rd_en     = (state_q == ST_RUN);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (sample_count == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (rd_cnt_q == count_q - ADDR_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (vld_q[PIPE_LAT] && (wr_cnt_q == count_q - ADDR_W'(1))) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Adder tree over the registered products.
    always_comb begin
        acc_sum = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            acc_sum = acc_sum + ACC_W'(prod_q[k]);
        end
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .DATA_W(DATA_W)
    ) u_round_sat (
        .acc  (acc_sum),
        .shift(shift_q),
        .value(rs_val),
        .sat  (rs_sat)
    );

    // Datapath next values: run setup, counters, delay line, products, result.
    always_comb begin
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        count_d    = count_q;
        shift_d    = shift_q;
        sat_d      = sat_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        y_d        = y_q;
        vld_d      = {vld_q[PIPE_LAT-1:1], rd_en};
        x_d        = x_q;
        coef_d     = coef_q;
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(x_q[k]) * PROD_W'(coef_q[k]);
        end

        if (start_acc) begin
            in_base_d  = input_addr;
            out_base_d = output_addr;
            count_d    = sample_count;
            shift_d    = out_shift;
            sat_d      = 1'b0;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_d[k] = '0;
            end
        end

        if (rd_en) begin
            rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        end

        // History only advances on real samples, so older taps stay zero.
        if (vld_q[1]) begin
            x_d[0] = mem_data_out_a;
            for (int unsigned k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end

        if (vld_q[3]) begin
            y_d = rs_val;
            if (rs_sat) sat_d = 1'b1;
        end

        if (vld_q[PIPE_LAT]) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end

        for (int unsigned k = 0; k < TAPS; k++) begin
            if (coef_we && !busy && (32'(coef_idx) == k)) begin
                coef_d[k] = coef_data;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            in_base_q  <= '0;
            out_base_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            sat_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            y_q        <= '0;
            vld_q      <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                prod_q[k] <= '0;
                coef_q[k] <= COEF_W'(reset_coef(k));
            end
        end else begin
            state_q    <= state_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            sat_q      <= sat_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            y_q        <= y_d;
            vld_q      <= vld_d;
            x_q        <= x_d;
            prod_q     <= prod_d;
            coef_q     <= coef_d;
        end
    end

    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign sat_flag      = sat_q;
    assign mem_addr_a    = in_base_q + rd_cnt_q;
    assign mem_rd_en_a   = rd_en;
    assign mem_addr_b    = out_base_q + wr_cnt_q;
    assign mem_data_in_b = y_q;
    assign mem_we_b      = vld_q[PIPE_LAT];

endmodule

// File: tb/tb_fir_param_pipelined.sv
// Self-checking bench for fir_param_pipelined with a RAM model and an
// arithmetic reference filter.
module tb_fir_param_pipelined;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int TP = 5;
    localparam int AW = 10;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] input_addr = '0;
    logic [AW-1:0] output_addr = '0;
    logic [AW-1:0] sample_count = '0;
    logic [4:0]    out_shift = '0;
    logic          coef_we = 1'b0;
    logic [3:0]    coef_idx = '0;
    logic [CW-1:0] coef_data = '0;
    logic          busy, done, sat_flag;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_rd_en_a, mem_we_b;
    logic signed [DW-1:0] mem_data_out_a = '0;
    logic signed [DW-1:0] mem_data_in_b;

    logic signed [DW-1:0] ram[MSZ];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rd_a[$], rd_c[$], wr_a[$], wr_d[$], wr_c[$];
    int xin[$];
    int mcoef[TP];

    fir_param_pipelined #(
        .DATA_W(DW),
        .COEF_W(CW),
        .TAPS  (TP),
        .ADDR_W(AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .input_addr    (input_addr),
        .output_addr   (output_addr),
        .sample_count  (sample_count),
        .out_shift     (out_shift),
        .coef_we       (coef_we),
        .coef_idx      (coef_idx),
        .coef_data     (coef_data),
        .busy          (busy),
        .done          (done),
        .sat_flag      (sat_flag),
        .mem_addr_a    (mem_addr_a),
        .mem_rd_en_a   (mem_rd_en_a),
        .mem_data_out_a(mem_data_out_a),
        .mem_addr_b    (mem_addr_b),
        .mem_data_in_b (mem_data_in_b),
        .mem_we_b      (mem_we_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port RAM: 1-cycle synchronous read, read-before-write.
    always @(posedge clk) begin
        if (mem_rd_en_a) mem_data_out_a <= ram[mem_addr_a];
        if (mem_we_b) ram[mem_addr_b] = mem_data_in_b;
    end

    // Port activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_rd_en_a) begin
            rd_a.push_back(int'(mem_addr_a));
            rd_c.push_back(cyc);
        end
        if (rst_n && mem_we_b) begin
            wr_a.push_back(int'(mem_addr_b));
            wr_d.push_back(int'(mem_data_in_b));
            wr_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: y[n] = sum coef[k]*x[n-k], round half up, shift, saturate.
    function automatic void model(input int n, input int sh, output int y, output bit s);
        longint acc = 0;
        for (int k = 0; k < TP; k++) begin
            if (n - k >= 0) acc += longint'(mcoef[k]) * longint'(xin[n - k]);
        end
        if (sh > 0) acc += longint'(1) << (sh - 1);
        acc = acc >>> sh;
        s = 1'b0;
        if (acc > 127) begin acc = 127; s = 1'b1; end
        if (acc < -128) begin acc = -128; s = 1'b1; end
        y = int'(acc);
    endfunction

    task automatic place(input int base);
        for (int i = 0; i < xin.size(); i++) ram[(base + i) % MSZ] = 8'(xin[i]);
    endtask

    task automatic set_coef(input int idx, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = 8'(val);
        @(negedge clk);
        coef_we = 1'b0;
        if (idx < TP) mcoef[idx] = val;
    endtask

    task automatic run(input int ia, input int oa, input int n, input int sh, input bit mid_we);
        int  s;
        int  y;
        bit  seen, ms, sany;
        rd_a.delete(); rd_c.delete();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        place(ia);
        @(negedge clk);
        input_addr   = AW'(ia);
        output_addr  = AW'(oa);
        sample_count = AW'(n);
        out_shift    = 5'(sh);
        start        = 1'b1;
        s            = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int t = 0; t < n + 40; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 0) begin
                check("busy_first", busy, (n > 0) ? 1 : 0);
                check("sat_cleared", sat_flag, 0);
            end
            coef_we   = mid_we && (t == 2);
            coef_idx  = 4'd0;
            coef_data = 8'sd77;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        coef_we = 1'b0;
        check("done_seen", seen, 1);
        if (seen) check("done_cycle", cyc, s + ((n == 0) ? 0 : n + 4));
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
        check("n_reads", rd_a.size(), n);
        check("n_writes", wr_a.size(), n);
        for (int i = 0; i < n && i < rd_a.size(); i++) begin
            check("rd_addr", rd_a[i], (ia + i) % MSZ);
            check("rd_cycle", rd_c[i], s + i);
        end
        sany = 1'b0;
        for (int i = 0; i < n && i < wr_a.size(); i++) begin
            model(i, sh, y, ms);
            sany |= ms;
            check("wr_addr", wr_a[i], (oa + i) % MSZ);
            check("wr_data", wr_d[i], y);
            check("wr_cycle", wr_c[i], s + i + 4);
        end
        check("sat_flag", sat_flag, sany);
    endtask

    initial begin
        for (int k = 0; k < TP; k++) mcoef[k] = (k == 0) ? 1 : 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_rd_en", mem_rd_en_a, 0);
        check("rst_we", mem_we_b, 0);
        rst_n = 1'b1;

        // Identity filter straight out of reset.
        xin = '{10, -20, 127, -128, 5};
        run(100, 200, 5, 0, 1'b0);

        // Symmetric 5-tap kernel; index beyond TAPS must be ignored.
        set_coef(0, 1); set_coef(1, 2); set_coef(2, 3); set_coef(3, 2); set_coef(4, 1);
        set_coef(9, 55);
        xin = '{10, 0, 0, 0, 0, 0};
        run(10, 40, 6, 0, 1'b0);
        xin = '{100, 100, 100, 100, 100, 100};
        run(10, 40, 6, 3, 1'b0);
        xin = '{-128, -128, -128, -128};
        run(10, 40, 4, 0, 1'b0);
        check("sat_sticky", sat_flag, 1);
        repeat (3) @(negedge clk);
        check("sat_sticky_idle", sat_flag, 1);

        // Empty run, then address wrap.
        xin.delete();
        run(500, 600, 0, 2, 1'b0);
        xin = '{1, 2, 3, 4};
        run(1022, 300, 4, 0, 1'b0);

        // Randomized runs: in-place on r==2, mid-run coefficient write on r==3.
        for (int r = 0; r < 6; r++) begin
            int n, ia, oa, sh;
            for (int k = 0; k < TP; k++) set_coef(k, int'($urandom_range(0, 255)) - 128);
            n  = int'($urandom_range(1, 30));
            sh = int'($urandom_range(0, 10));
            ia = int'($urandom_range(0, MSZ - 1));
            oa = (r == 2) ? ia : (ia + MSZ / 2) % MSZ;
            xin.delete();
            for (int i = 0; i < n; i++) xin.push_back(int'($urandom_range(0, 255)) - 128);
            run(ia, oa, n, sh, (r == 3));
        end

        // Asynchronous reset in the middle of a saturating run.
        for (int k = 0; k < TP; k++) set_coef(k, 127);
        xin.delete();
        for (int i = 0; i < 20; i++) xin.push_back(100);
        place(300);
        @(negedge clk);
        input_addr = AW'(300); output_addr = AW'(700); sample_count = AW'(20);
        out_shift = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_sat", sat_flag, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_sat", sat_flag, 0);
        check("mid_rst_rd_en", mem_rd_en_a, 0);
        check("mid_rst_we", mem_we_b, 0);
        check("mid_rst_addr_a", mem_addr_a, 0);
        check("mid_rst_addr_b", mem_addr_b, 0);
        check("mid_rst_data_b", mem_data_in_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < TP; k++) mcoef[k] = (k == 0) ? 1 : 0;
        xin.delete();
        for (int i = 0; i < 8; i++) xin.push_back(int'($urandom_range(0, 255)) - 128);
        run(50, 900, 8, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
